mem_request_arbiter: RTL and testbench
======================================

Name: mem_request_arbiter

Overview:
- Upstream stage of the RAM controller: accepts 64-bit memory requests from two CPU-side ports (A = instruction fetch, read-only; B = load/store, read/write).
- Grants one requester at a time (round-robin) and latches its address and data.
- Drives the controller's read/write/address/datain, waits on its done, and returns read data with a one-cycle ack.
- Watchdog aborts a transaction if the controller never answers.

Parameters:
- ADDR_W, 64, request address width, passed straight to the controller.
- DATA_W, 64, data word width.
- TIMEOUT_CYCLES, 64, cycles allowed in WAIT_DONE or RELEASE before abort; must be at least 16.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- resetin  in  1  asynchronous, active-low reset.
- a_req  in  1  port A read request; held until a_ack.
- a_addr  in  ADDR_W  port A address.
- a_ack  out  1  one-cycle completion pulse for port A.
- b_req  in  1  port B request; held until b_ack.
- b_we  in  1  port B: 1 = write, 0 = read.
- b_addr  in  ADDR_W  port B address.
- b_wdata  in  DATA_W  port B write data.
- b_ack  out  1  one-cycle completion pulse for port B.
- rdata  out  DATA_W  read data; valid in the ack cycle, held until the next ack.
- err  out  1  high with an ack when that transaction timed out.
- mem_address  out  ADDR_W  to controller address.
- mem_datain  out  DATA_W  to controller datain.
- mem_read  out  1  to controller read.
- mem_write  out  1  to controller write.
- mem_dataout  in  DATA_W  from controller dataout.
- mem_done  in  1  from controller done; treated as a level.

Behaviour:
- Reset (resetin low, asynchronous):
  - State = IDLE.
  - All outputs 0: a_ack, b_ack, err, rdata, mem_address, mem_datain, mem_read, mem_write.
  - last_grant = B, so A wins the first tie.
  - Timeout counter = 0.
- Reset mid-transaction: strobes drop immediately and no ack is issued.
- States: IDLE, WAIT_DONE, RELEASE.
- IDLE:
  - If mem_done = 1, remain in IDLE (controller not yet quiescent).
  - Otherwise, grant when any req = 1:
    - Only one requester active: that requester is granted.
    - Both active: grant the one not equal to last_grant.
  - On grant:
    - Latch address into mem_address.
    - For B: latch b_wdata into mem_datain; set mem_write = b_we and mem_read = ~b_we.
    - For A: set mem_read = 1.
    - Update last_grant; clear counter; go to WAIT_DONE.
  - Strobes are therefore visible the cycle after req is sampled.
- WAIT_DONE:
  - Strobes and latched address/data held stable; counter increments.
  - On mem_done = 1:
    - rdata <= mem_dataout for a read; rdata unchanged for a write.
    - Pulse the granted ack for one cycle with err = 0.
    - Drop mem_read/mem_write; clear counter; go to RELEASE.
  - If the counter reaches TIMEOUT_CYCLES-1 first:
    - Drop strobes; pulse ack with err = 1; rdata <= 0; go to RELEASE.
- RELEASE:
  - Wait for mem_done = 0, then go to IDLE; counter increments.
  - On timeout here: go to IDLE anyway (no further ack; err not re-raised).
- Ack rules:
  - Exactly one ack per grant.
  - a_ack and b_ack are never high together.
  - err is high only in an ack cycle.
- Requesters:
  - Inputs are sampled only at grant; later changes are ignored.
  - Dropping req before grant is legal.
  - req still high after ack counts as a new request (earliest grant is the first IDLE cycle).
- Minimum request-to-ack latency: 3 cycles (grant edge, done seen, ack).
- No buffering: one outstanding transaction maximum.

Decomposition:
- Shared package memreq_pkg:
  - state enum (IDLE / WAIT_DONE / RELEASE).
  - grant encoding constants (GRANT_A = 0, GRANT_B = 1).
  - Default ADDR_W/DATA_W.
- Sub-module rr_arbiter2: 2-input round-robin grant from req bits and last_grant, purely combinational. Everything else stays in the top module.

Test Plan:
- Single read, port A: a_addr = 0x0000_0000_0000_1000, a_req held; model raises mem_done 10 cycles after mem_read with dataout 0xDEAD_BEEF_0123_4567 -> mem_read high the cycle after grant; a_ack one cycle, rdata = 0xDEAD_BEEF_0123_4567, err = 0; mem_read low in the ack cycle.
- Port B write: b_we = 1, b_addr = 0x40, b_wdata = 0x1122_3344_5566_7788 -> mem_write = 1, mem_read = 0, mem_datain equal to b_wdata for the whole of WAIT_DONE; b_ack pulses; rdata unchanged.
- Simultaneous requests out of reset, both held for 4 transactions -> grant order A, B, A, B; acks never overlap.
- Sticky mem_done: model keeps done high 5 cycles after strobes drop -> block stays in RELEASE; next grant only after done falls.
- Timeout: mem_done never rises, TIMEOUT_CYCLES = 64 -> ack with err = 1 and rdata = 0 at cycle 64 after grant; strobes low; the next request is served normally.
- Async reset asserted mid-WAIT_DONE -> mem_read/mem_write low immediately with no clock edge; no ack; after release, A is granted first on a tie.

Source files
------------

// File: rtl/memreq_pkg.sv
// Shared types and constants for the memory request arbiter.
package memreq_pkg;

    localparam int DEF_ADDR_W = 64;
    localparam int DEF_DATA_W = 64;

    // Grant encoding, also used as the last_grant value
    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        RELEASE   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant. The requester that did not win last time
// takes a tie; a lone requester always wins.
module rr_arbiter2
    import memreq_pkg::*;
(
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_last_grant,
    output logic o_valid,
    output logic o_grant
);

    // Pick a winner from the request bits and the previous winner
    always_comb begin
        o_valid = i_req_a | i_req_b;
        o_grant = GRANT_A;
        if (i_req_a && i_req_b) begin
            o_grant = (i_last_grant == GRANT_A) ? GRANT_B : GRANT_A;
        end else if (i_req_b) begin
            o_grant = GRANT_B;
        end
    end

endmodule

// File: rtl/mem_request_arbiter.sv
// Front end of the RAM controller: arbitrates two CPU-side ports, drives one
// controller transaction at a time and returns an ack (with err on timeout).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no transaction; grant when controller done is low
// WAIT_DONE | strobes held, waiting for done or the watchdog
// RELEASE   | strobes low, waiting for the controller to drop done
module mem_request_arbiter
    import memreq_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    // Must be at least 16
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clock,
    input  logic              resetin,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_datain,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_dataout,
    input  logic              mem_done
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            r_state;
    logic              r_last_grant;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic              r_a_ack;
    logic              r_b_ack;
    logic              r_err;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_datain;
    logic              r_mem_read;
    logic              r_mem_write;

    state_t            w_state_nxt;
    logic              w_last_grant_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic              w_a_ack_nxt;
    logic              w_b_ack_nxt;
    logic              w_err_nxt;
    logic [ADDR_W-1:0] w_mem_address_nxt;
    logic [DATA_W-1:0] w_mem_datain_nxt;
    logic              w_mem_read_nxt;
    logic              w_mem_write_nxt;

    logic              w_arb_valid;
    logic              w_arb_grant;

    rr_arbiter2 u_rr_arbiter2 (
        .i_req_a      (a_req),
        .i_req_b      (b_req),
        .i_last_grant (r_last_grant),
        .o_valid      (w_arb_valid),
        .o_grant      (w_arb_grant)
    );

    // State and output registers; reset drops strobes without a clock edge
    always_ff @(posedge clock or negedge resetin) begin
        if (!resetin) begin
            r_state       <= IDLE;
            r_last_grant  <= GRANT_B;
            r_cnt         <= '0;
            r_rdata       <= '0;
            r_a_ack       <= 1'b0;
            r_b_ack       <= 1'b0;
            r_err         <= 1'b0;
            r_mem_address <= '0;
            r_mem_datain  <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_last_grant  <= w_last_grant_nxt;
            r_cnt         <= w_cnt_nxt;
            r_rdata       <= w_rdata_nxt;
            r_a_ack       <= w_a_ack_nxt;
            r_b_ack       <= w_b_ack_nxt;
            r_err         <= w_err_nxt;
            r_mem_address <= w_mem_address_nxt;
            r_mem_datain  <= w_mem_datain_nxt;
            r_mem_read    <= w_mem_read_nxt;
            r_mem_write   <= w_mem_write_nxt;
        end
    end

    // Next-state and next-output logic; acks and err default low so they pulse
    always_comb begin
        w_state_nxt       = r_state;
        w_last_grant_nxt  = r_last_grant;
        w_cnt_nxt         = r_cnt;
        w_rdata_nxt       = r_rdata;
        w_a_ack_nxt       = 1'b0;
        w_b_ack_nxt       = 1'b0;
        w_err_nxt         = 1'b0;
        w_mem_address_nxt = r_mem_address;
        w_mem_datain_nxt  = r_mem_datain;
        w_mem_read_nxt    = r_mem_read;
        w_mem_write_nxt   = r_mem_write;

        case (r_state)
            IDLE: begin
                // A done still high from the last transaction blocks new grants
                if (!mem_done && w_arb_valid) begin
                    w_last_grant_nxt = w_arb_grant;
                    w_cnt_nxt        = '0;
                    w_state_nxt      = WAIT_DONE;
                    if (w_arb_grant == GRANT_B) begin
                        w_mem_address_nxt = b_addr;
                        w_mem_datain_nxt  = b_wdata;
                        w_mem_write_nxt   = b_we;
                        w_mem_read_nxt    = ~b_we;
                    end else begin
                        w_mem_address_nxt = a_addr;
                        w_mem_write_nxt   = 1'b0;
                        w_mem_read_nxt    = 1'b1;
                    end
                end
            end

            WAIT_DONE: begin
                if (mem_done) begin
                    if (r_mem_read) begin
                        w_rdata_nxt = mem_dataout;
                    end
                    w_a_ack_nxt     = (r_last_grant == GRANT_A);
                    w_b_ack_nxt     = (r_last_grant == GRANT_B);
                    w_mem_read_nxt  = 1'b0;
                    w_mem_write_nxt = 1'b0;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = RELEASE;
                end else if (r_cnt == CNT_MAX) begin
                    w_a_ack_nxt     = (r_last_grant == GRANT_A);
                    w_b_ack_nxt     = (r_last_grant == GRANT_B);
                    w_err_nxt       = 1'b1;
                    w_rdata_nxt     = '0;
                    w_mem_read_nxt  = 1'b0;
                    w_mem_write_nxt = 1'b0;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = RELEASE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            RELEASE: begin
                // A controller stuck with done high is abandoned silently
                if (!mem_done || (r_cnt == CNT_MAX)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            default: begin
                w_state_nxt     = IDLE;
                w_mem_read_nxt  = 1'b0;
                w_mem_write_nxt = 1'b0;
                w_cnt_nxt       = '0;
            end
        endcase
    end

    assign a_ack       = r_a_ack;
    assign b_ack       = r_b_ack;
    assign err         = r_err;
    assign rdata       = r_rdata;
    assign mem_address = r_mem_address;
    assign mem_datain  = r_mem_datain;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Bench for mem_request_arbiter: behavioural controller model plus an
// ack scoreboard filled as requests are driven.
module tb_mem_request_arbiter;
    import memreq_pkg::*;

    localparam int ADDR_W         = 64;
    localparam int DATA_W         = 64;
    localparam int TIMEOUT_CYCLES = 64;

    logic              clock   = 1'b0;
    logic              resetin = 1'b0;
    logic              a_req;
    logic [ADDR_W-1:0] a_addr;
    logic              a_ack;
    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_datain;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_dataout = '0;
    logic              mem_done    = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic              port;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } exp_t;
    exp_t sb[$];

    // controller model knobs
    int                m_delay    = 10;
    int                m_sticky   = 0;
    bit                m_never    = 1'b0;
    bit                m_use_addr = 1'b0;
    logic [DATA_W-1:0] m_data     = 64'hDEAD_BEEF_0123_4567;
    int                m_cnt      = 0;
    int                m_hold     = 0;

    logic [DATA_W-1:0] exp_rd = '0;
    logic [DATA_W-1:0] wr_data;
    logic              prev_a = 1'b0;
    logic              prev_b = 1'b0;
    int                n;

    mem_request_arbiter #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clock       (clock),
        .resetin     (resetin),
        .a_req       (a_req),
        .a_addr      (a_addr),
        .a_ack       (a_ack),
        .b_req       (b_req),
        .b_we        (b_we),
        .b_addr      (b_addr),
        .b_wdata     (b_wdata),
        .b_ack       (b_ack),
        .rdata       (rdata),
        .err         (err),
        .mem_address (mem_address),
        .mem_datain  (mem_datain),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_dataout (mem_dataout),
        .mem_done    (mem_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input logic port, input logic e, input logic [DATA_W-1:0] d);
        exp_t x;
        x.port  = port;
        x.err   = e;
        x.rdata = d;
        sb.push_back(x);
    endtask

    // Waits (bounded) for the next ack; returns at the negedge it is seen
    task automatic wait_ack(input string tag, input int budget);
        int k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!(a_ack || b_ack) && k < budget);
        check(tag, a_ack | b_ack, 1'b1);
    endtask

    // Controller model: done after m_delay strobe cycles, held m_sticky
    // cycles after the strobes drop; m_never suppresses done entirely
    always @(posedge clock) begin
        #1;
        if (!resetin) begin
            mem_done    = 1'b0;
            mem_dataout = '0;
            m_cnt       = 0;
            m_hold      = 0;
        end else if (mem_read || mem_write) begin
            m_hold = m_sticky;
            if (!m_never && !mem_done) begin
                m_cnt++;
                if (m_cnt >= m_delay) begin
                    mem_done    = 1'b1;
                    mem_dataout = m_data ^ (m_use_addr ? mem_address : '0);
                end
            end
        end else begin
            m_cnt = 0;
            if (mem_done) begin
                if (m_hold > 0) m_hold--;
                else mem_done = 1'b0;
            end
        end
    end

    // Ack monitor: pops the scoreboard on every ack
    always @(negedge clock) begin
        if (resetin) begin
            check("err_without_ack", err & ~(a_ack | b_ack), 1'b0);
            if (a_ack || b_ack) begin
                check("ack_overlap", a_ack & b_ack, 1'b0);
                check("ack_strobes_low", mem_read | mem_write, 1'b0);
                check("ack_single_pulse", (a_ack & prev_a) | (b_ack & prev_b), 1'b0);
                if (sb.size() == 0) begin
                    check("unexpected_ack", a_ack | b_ack, 1'b0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ack_port", b_ack, e.port);
                    check("ack_err", err, e.err);
                    check("ack_rdata", rdata, e.rdata);
                end
            end
            prev_a = a_ack;
            prev_b = b_ack;
        end else begin
            prev_a = 1'b0;
            prev_b = 1'b0;
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_req = 1'b0; a_addr = '0; b_req = 1'b0; b_we = 1'b0;
        b_addr = '0; b_wdata = '0;
        repeat (3) @(negedge clock);
        check("rst_a_ack", a_ack, 1'b0);
        check("rst_b_ack", b_ack, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_rdata", rdata, 64'h0);
        check("rst_mem_address", mem_address, 64'h0);
        check("rst_mem_datain", mem_datain, 64'h0);
        check("rst_mem_read", mem_read, 1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        resetin = 1'b1;

        // single read on port A
        @(negedge clock);
        m_delay = 10; m_use_addr = 1'b0; m_data = 64'hDEAD_BEEF_0123_4567;
        a_addr = 64'h0000_0000_0000_1000; a_req = 1'b1;
        exp_rd = 64'hDEAD_BEEF_0123_4567;
        push_exp(GRANT_A, 1'b0, exp_rd);
        @(negedge clock);
        check("a_rd_strobe", mem_read, 1'b1);
        check("a_rd_nowrite", mem_write, 1'b0);
        check("a_rd_addr", mem_address, 64'h1000);
        wait_ack("a_rd_ack", 40);
        check("a_rd_ack_port", a_ack, 1'b1);
        a_req = 1'b0;

        // write on port B; inputs scrambled after grant must not leak through
        @(negedge clock);
        m_delay = 4;
        wr_data = 64'h1122_3344_5566_7788;
        b_we = 1'b1; b_addr = 64'h40; b_wdata = wr_data; b_req = 1'b1;
        push_exp(GRANT_B, 1'b0, exp_rd);
        @(negedge clock);
        check("b_wr_addr", mem_address, 64'h40);
        b_wdata = ~wr_data; b_addr = 64'hFFFF; b_we = 1'b0;
        for (int i = 0; i < 50 && !(a_ack || b_ack); i++) begin
            check("b_wr_datain", mem_datain, wr_data);
            check("b_wr_write", mem_write, 1'b1);
            check("b_wr_read", mem_read, 1'b0);
            @(negedge clock);
        end
        check("b_wr_ack", b_ack, 1'b1);
        b_req = 1'b0;

        // both held for four transactions: A, B, A, B
        @(negedge clock);
        m_delay = 3; m_use_addr = 1'b1; m_data = 64'hA5A5_0000_5A5A_0000;
        a_addr = 64'h100; b_addr = 64'h200; b_we = 1'b0; b_wdata = '0;
        a_req = 1'b1; b_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_rd = m_data ^ ((i % 2 == 0) ? 64'h100 : 64'h200);
            push_exp((i % 2 == 0) ? GRANT_A : GRANT_B, 1'b0, exp_rd);
        end
        for (int i = 0; i < 4; i++) begin
            wait_ack("tie_ack", 40);
            check("tie_order_b", b_ack, (i % 2 == 1));
        end
        a_req = 1'b0; b_req = 1'b0;

        // sticky done: no new grant while done stays high after the ack
        @(negedge clock);
        m_sticky = 5; m_delay = 2;
        a_addr = 64'h300; a_req = 1'b1;
        exp_rd = m_data ^ 64'h300;
        push_exp(GRANT_A, 1'b0, exp_rd);
        wait_ack("sticky_a_ack", 40);
        a_req = 1'b0;
        b_we = 1'b0; b_addr = 64'h400; b_req = 1'b1;
        exp_rd = m_data ^ 64'h400;
        push_exp(GRANT_B, 1'b0, exp_rd);
        for (int i = 0; i < 20 && mem_done; i++) begin
            @(negedge clock);
            check("sticky_no_grant", mem_read | mem_write, 1'b0);
        end
        m_sticky = 0;
        wait_ack("sticky_b_ack", 40);
        check("sticky_b_port", b_ack, 1'b1);
        b_req = 1'b0;

        // timeout: controller never answers
        @(negedge clock);
        m_never = 1'b1;
        a_addr = 64'h500; a_req = 1'b1;
        exp_rd = '0;
        push_exp(GRANT_A, 1'b1, exp_rd);
        @(negedge clock);
        check("to_strobe", mem_read, 1'b1);
        n = 0;
        while (!(a_ack || b_ack) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("to_latency", n, TIMEOUT_CYCLES);
        check("to_err", err, 1'b1);
        a_req = 1'b0;
        m_never = 1'b0;
        @(negedge clock);
        b_we = 1'b0; b_addr = 64'h600; b_req = 1'b1;
        exp_rd = m_data ^ 64'h600;
        push_exp(GRANT_B, 1'b0, exp_rd);
        wait_ack("post_to_ack", 40);
        b_req = 1'b0;

        // async reset in the middle of WAIT_DONE
        @(negedge clock);
        m_delay = 20;
        a_addr = 64'h700; a_req = 1'b1;
        @(negedge clock);
        check("rst_mid_strobe_before", mem_read, 1'b1);
        repeat (3) @(negedge clock);
        #2 resetin = 1'b0;
        #1;
        check("rst_mid_read", mem_read, 1'b0);
        check("rst_mid_write", mem_write, 1'b0);
        check("rst_mid_addr", mem_address, 64'h0);
        check("rst_mid_rdata", rdata, 64'h0);
        @(negedge clock);
        m_delay = 3;
        b_we = 1'b0; b_addr = 64'h800; b_req = 1'b1;
        push_exp(GRANT_A, 1'b0, m_data ^ 64'h700);
        push_exp(GRANT_B, 1'b0, m_data ^ 64'h800);
        @(negedge clock);
        resetin = 1'b1;
        wait_ack("rst_tie_first", 40);
        check("rst_tie_a_first", a_ack, 1'b1);
        a_req = 1'b0;
        wait_ack("rst_tie_second", 40);
        check("rst_tie_b_second", b_ack, 1'b1);
        b_req = 1'b0;

        repeat (5) @(negedge clock);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
